msgsink: RTL and testbench

Write-side companion to the core-ID string register on the ZX-UNO register bus: the CPU streams a short ASCII string, one byte per write strobe to a single register address, and the block assembles it into a 16-byte buffer. When a NUL byte arrives or the buffer fills, the string is committed and handed to an on-chip consumer (OSD, status display) through a random-access read port with a valid/ack handshake.

---
 rtl/msgsink.sv | 125 ++++++++++++
 tb/tb_msgsink.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/msgsink.sv
// msgsink: assembles a CPU-written ASCII string into a 16-byte buffer.
// Optional status readback port enabled by defining MSGSINK_READBACK_EN.
module msgsink #(
   parameter logic [7:0] REGADDR = 8'hFE
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] zxuno_addr,
   input  logic       zxuno_regwr,
   input  logic       regaddr_changed,
   input  logic [7:0] din,
   input  logic [3:0] rd_addr,
   output logic [7:0] rd_data,
   output logic       msg_valid,
   output logic [4:0] msg_len,
   input  logic       msg_ack
`ifdef MSGSINK_READBACK_EN
   ,
   input  logic       zxuno_regrd,
   output logic       oe_n,
   output logic [7:0] dout
`endif
);

   typedef enum logic [1:0] {
      EMPTY,
      FILLING,
      FULL
   } state_t;

   state_t     state;
   logic       sel;
   logic       sel_q;
   logic       armed;
   logic       rise;
   logic       fall;
   logic       abort;
   logic       term;
   logic       active;
   logic       wr;
   logic [4:0] idx;
   logic [4:0] idx_nx;
   logic [4:0] len;
   logic [7:0] mem [16];

   // armed blocks a strobe already high at reset release from counting
   assign sel    = (zxuno_addr == REGADDR) && zxuno_regwr;
   assign rise   = sel && !sel_q && armed;
   assign fall   = !sel && sel_q;
   assign abort  = regaddr_changed && (zxuno_addr == REGADDR)
                   && (state != FULL);
   assign wr     = rise && (state != FULL) && !abort;
   assign idx_nx = idx + 5'd1;
   assign msg_len = len;

   // message assembly state machine with registered status outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= EMPTY;
         idx       <= 5'd0;
         len       <= 5'd0;
         sel_q     <= 1'b0;
         armed     <= 1'b0;
         term      <= 1'b0;
         active    <= 1'b0;
         msg_valid <= 1'b0;
      end else begin
         sel_q <= sel;
         armed <= armed | ~sel;
         if (abort) begin
            idx    <= 5'd0;
            state  <= EMPTY;
            active <= 1'b0;
            term   <= 1'b0;
         end else if (state == FULL) begin
            if (msg_ack) begin
               state     <= EMPTY;
               msg_valid <= 1'b0;
            end
         end else if (rise) begin
            state  <= FILLING;
            active <= 1'b1;
            term   <= (din == 8'h00);
         end else if (fall && active) begin
            active <= 1'b0;
            term   <= 1'b0;
            if (term) begin
               len       <= idx;
               state     <= FULL;
               msg_valid <= 1'b1;
               idx       <= 5'd0;
            end else if (idx_nx == 5'd16) begin
               len       <= 5'd16;
               state     <= FULL;
               msg_valid <= 1'b1;
               idx       <= 5'd0;
            end else begin
               idx <= idx_nx;
            end
         end
      end
   end

   // byte store on a captured strobe rising edge; contents not reset
   always_ff @(posedge clk) begin
      if (wr) mem[idx[3:0]] <= din;
   end

   // registered random-access read port
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_data <= 8'h00;
      else     rd_data <= mem[rd_addr];
   end

`ifdef MSGSINK_READBACK_EN
   assign oe_n = !((zxuno_addr == REGADDR) && zxuno_regrd);

   // status byte: valid, filling, zero, committed length
   always_ff @(posedge clk or posedge rst) begin
      if (rst) dout <= 8'h00;
      else     dout <= {msg_valid, state == FILLING, 1'b0, len};
   end
`endif

endmodule

// File: tb/tb_msgsink.sv
// tb_msgsink: scoreboard bench for msgsink.
// Expected bytes queued at write time, popped when the message is read.
module tb_msgsink;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] zxuno_addr = 8'h00;
   logic       zxuno_regwr = 1'b0;
   logic       regaddr_changed = 1'b0;
   logic [7:0] din = 8'h00;
   logic [3:0] rd_addr = 4'd0;
   logic [7:0] rd_data;
   logic       msg_valid;
   logic [4:0] msg_len;
   logic       msg_ack = 1'b0;
`ifdef MSGSINK_READBACK_EN
   logic       zxuno_regrd = 1'b0;
   logic       oe_n;
   logic [7:0] dout;
`endif

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q [$];

   msgsink #(.REGADDR(8'hFE)) dut (
      .clk(clk),
      .rst(rst),
      .zxuno_addr(zxuno_addr),
      .zxuno_regwr(zxuno_regwr),
      .regaddr_changed(regaddr_changed),
      .din(din),
      .rd_addr(rd_addr),
      .rd_data(rd_data),
      .msg_valid(msg_valid),
      .msg_len(msg_len),
      .msg_ack(msg_ack)
`ifdef MSGSINK_READBACK_EN
      ,
      .zxuno_regrd(zxuno_regrd),
      .oe_n(oe_n),
      .dout(dout)
`endif
   );

   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // one CPU write, strobe held for hold clocks; push=1 queues it
   task automatic wr_byte(input logic [7:0] d, input bit push);
      @(negedge clk);
      zxuno_addr  = 8'hFE;
      din         = d;
      zxuno_regwr = 1'b1;
      cyc(4);
      zxuno_regwr = 1'b0;
      cyc(2);
      if (push && d != 8'h00) exp_q.push_back(d);
   endtask

   task automatic read_at(input logic [3:0] a, output logic [7:0] d);
      @(negedge clk);
      rd_addr = a;
      @(negedge clk);
      d = rd_data;
   endtask

   // compare committed message against the scoreboard queue
   task automatic check_msg(input string nm);
      logic [7:0] d;
      logic [7:0] e;
      int n;
      n = exp_q.size();
      checks++;
      if (msg_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s valid got %b exp 1", nm, msg_valid);
      end
      checks++;
      if (msg_len !== 5'(n)) begin
         errors++;
         $display("FAIL %s len got %0d exp %0d", nm, msg_len, n);
      end
      for (int i = 0; i < n; i++) begin
         e = exp_q.pop_front();
         read_at(4'(i), d);
         checks++;
         if (d !== e) begin
            errors++;
            $display("FAIL %s byte%0d got %h exp %h", nm, i, d, e);
         end
      end
      exp_q.delete();
   endtask

   task automatic ack_check(input string nm);
      @(negedge clk);
      msg_ack = 1'b1;
      @(negedge clk);
      msg_ack = 1'b0;
      checks++;
      if (msg_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s ack valid got %b exp 0", nm, msg_valid);
      end
   endtask

   task automatic test_reset;
      cyc(2);
      checks++;
      if (msg_valid !== 1'b0 || msg_len !== 5'd0 || rd_data !== 8'h00) begin
         errors++;
         $display("FAIL reset got v%b l%0d d%h exp 0/0/00",
                  msg_valid, msg_len, rd_data);
      end
      rst = 1'b0;
      cyc(2);
   endtask

   task automatic test_hi;
      wr_byte(8'h48, 1);
      wr_byte(8'h49, 1);
      wr_byte(8'h00, 1);
      check_msg("hi");
      ack_check("hi");
   endtask

   task automatic test_full;
      logic [7:0] d;
      for (int i = 0; i < 16; i++) wr_byte(8'(8'h41 + i), 1);
      wr_byte(8'h51, 0);
      check_msg("full");
      read_at(4'd0, d);
      checks++;
      if (d !== 8'h41) begin
         errors++;
         $display("FAIL full17 buf0 got %h exp 41", d);
      end
      ack_check("full");
   endtask

   task automatic test_abort;
      wr_byte(8'h41, 0);
      wr_byte(8'h42, 0);
      @(negedge clk);
      regaddr_changed = 1'b1;
      @(negedge clk);
      regaddr_changed = 1'b0;
      checks++;
      if (msg_valid !== 1'b0) begin
         errors++;
         $display("FAIL abort valid got %b exp 0", msg_valid);
      end
      wr_byte(8'h5A, 1);
      wr_byte(8'h00, 1);
      check_msg("abort");
      ack_check("abort");
   endtask

   task automatic test_ack_collision;
      logic [7:0] d;
      wr_byte(8'h58, 1);
      wr_byte(8'h00, 1);
      check_msg("coll_pre");
      @(negedge clk);
      msg_ack     = 1'b1;
      din         = 8'h55;
      zxuno_regwr = 1'b1;
      @(negedge clk);
      msg_ack = 1'b0;
      cyc(3);
      zxuno_regwr = 1'b0;
      cyc(2);
      checks++;
      if (msg_valid !== 1'b0) begin
         errors++;
         $display("FAIL coll valid got %b exp 0", msg_valid);
      end
      read_at(4'd0, d);
      checks++;
      if (d !== 8'h58) begin
         errors++;
         $display("FAIL coll buf0 got %h exp 58", d);
      end
      wr_byte(8'h51, 1);
      wr_byte(8'h00, 1);
      check_msg("coll_post");
      ack_check("coll_post");
   endtask

   task automatic test_rst_mid;
      wr_byte(8'h61, 0);
      wr_byte(8'h62, 0);
      wr_byte(8'h63, 0);
      @(negedge clk);
      din         = 8'h64;
      zxuno_regwr = 1'b1;
      cyc(2);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (msg_valid !== 1'b0 || msg_len !== 5'd0 || rd_data !== 8'h00) begin
         errors++;
         $display("FAIL rstmid got v%b l%0d d%h exp 0/0/00",
                  msg_valid, msg_len, rd_data);
      end
      rst = 1'b0;
      cyc(3);
      zxuno_regwr = 1'b0;
      cyc(2);
      wr_byte(8'h4B, 1);
      wr_byte(8'h00, 1);
      check_msg("rstmid");
      ack_check("rstmid");
   endtask

   task automatic test_zero_len;
      wr_byte(8'h00, 1);
      check_msg("zero");
      ack_check("zero");
   endtask

`ifdef MSGSINK_READBACK_EN
   task automatic test_readback;
      for (int i = 0; i < 5; i++) wr_byte(8'(8'h30 + i), 1);
      wr_byte(8'h00, 1);
      @(negedge clk);
      zxuno_regrd = 1'b1;
      @(negedge clk);
      checks++;
      if (oe_n !== 1'b0 || dout !== 8'h85) begin
         errors++;
         $display("FAIL readback got oe%b d%h exp 0/85", oe_n, dout);
      end
      zxuno_regrd = 1'b0;
      check_msg("readback");
      ack_check("readback");
   endtask
`endif

   initial begin
      test_reset;
      test_hi;
      test_full;
      test_abort;
      test_ack_collision;
      test_rst_mid;
      test_zero_len;
`ifdef MSGSINK_READBACK_EN
      test_readback;
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
